// File: rtl/pipe_pkg.sv
// Shared types, state encodings and helpers for the pipeline control unit.
package pipe_pkg;

  localparam int unsigned MAX_W = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_IDLE  = 2'd3;

  // Lowest set bit index of v; returns 1 when any bit is set.
  function automatic logic lowest_set(input logic [MAX_W-1:0] v, output int unsigned idx);
    logic found;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < int'(MAX_W); i++) begin
      if (v[i] && !found) begin
        found = 1'b1;
        idx   = i;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/pipe_prio_enc.sv
// Lowest-set-index priority encoder (index 0 = oldest stage wins).
module pipe_prio_enc
  import pipe_pkg::*;
#(
  parameter  int unsigned W     = 5,
  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  int unsigned w_idx;

  // Widen to the helper's fixed width and narrow the index back.
  always_comb begin
    w_idx   = 0;
    o_found = lowest_set(MAX_W'(i_vec), w_idx);
    o_idx   = IDX_W'(w_idx);
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// In-order pipeline control: bubble tracking, stall/flush resolution,
// multi-cycle hold with countdown and a drain/quiesce handshake.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl_unit
  import pipe_pkg::*;
#(
  parameter  int unsigned STAGES = 5,
  parameter  int unsigned CNT_W  = 4
`ifdef PIPE_CTRL_STATS_EN
  , parameter int unsigned STAT_W = 32
`endif
  , localparam int unsigned IDX_W = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  input  logic              hold_req,
  input  logic [IDX_W-1:0]  hold_stage,
  input  logic [CNT_W-1:0]  hold_len,
  input  logic              drain_req,
  output logic [STAGES-1:0] keep,
  output logic [STAGES-1:0] dirty,
  output logic [STAGES-1:0] valid,
  output logic              busy,
  output logic              drained
`ifdef PIPE_CTRL_STATS_EN
  , output logic [STAT_W-1:0] stall_cycles
  , output logic [STAT_W-1:0] flush_events
  , output logic [STAT_W-1:0] bubble_retired
`endif
);

  state_t             r_state;
  state_t             w_state_next;
  logic [STAGES-1:0]  r_bubble;
  logic [STAGES-1:0]  w_bubble_next;
  logic [STAGES-1:0]  w_nb;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [IDX_W-1:0]   r_hold_stage;
  logic [IDX_W-1:0]   w_hold_stage_next;
  logic               r_busy;
  logic               r_drained;
  logic [STAGES-1:0]  w_es;
  logic [IDX_W-1:0]   w_s_idx;
  logic               w_s_found;
  logic [IDX_W-1:0]   w_f_idx;
  logic               w_f_found;
  logic               w_hold_ok;
  logic               w_abort;

  // Effective stall: external requests plus internal hold and drain blocking.
  always_comb begin
    w_es = stall;
    if (r_state == ST_HOLD) w_es[r_hold_stage] = 1'b1;
    if ((r_state == ST_DRAIN) || (r_state == ST_IDLE)) w_es[STAGES-1] = 1'b1;
  end

  pipe_prio_enc #(.W(STAGES)) u_es_enc (
    .i_vec   (w_es),
    .o_idx   (w_s_idx),
    .o_found (w_s_found)
  );

  pipe_prio_enc #(.W(STAGES)) u_fl_enc (
    .i_vec   (flush),
    .o_idx   (w_f_idx),
    .o_found (w_f_found)
  );

  assign w_hold_ok = hold_req && (hold_len != '0);
  assign w_abort   = (r_state == ST_HOLD) && w_f_found && (w_f_idx <= r_hold_stage);

  // Next bubble vector: flush first, then stall/advance.
  always_comb begin
    w_nb = r_bubble;
    if (w_f_found) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (IDX_W'(i) >= w_f_idx) w_nb[i] = 1'b1;
      end
    end
    w_bubble_next = w_nb;
    if (w_s_found) begin
      for (int i = 0; i < int'(STAGES) - 1; i++) begin
        if (IDX_W'(i) < w_s_idx) w_bubble_next[i] = w_nb[i+1];
      end
      w_bubble_next[w_s_idx] = 1'b1;
    end else begin
      w_bubble_next = {1'b0, w_nb[STAGES-1:1]};
    end
  end

  // Stage controls: prefix-OR of stall and flush towards younger stages.
  always_comb begin
    logic acc_s;
    logic acc_f;
    acc_s = 1'b0;
    acc_f = 1'b0;
    keep  = '0;
    dirty = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      acc_s    = acc_s | w_es[i];
      acc_f    = acc_f | flush[i];
      keep[i]  = acc_s;
      dirty[i] = r_bubble[i] | acc_f | acc_s;
    end
  end

  // Next-state and hold counter.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_hold_stage_next = r_hold_stage;
    case (r_state)
      ST_RUN: begin
        if (w_hold_ok) begin
          w_state_next      = ST_HOLD;
          w_cnt_next        = hold_len;
          w_hold_stage_next = hold_stage;
        end else if (drain_req) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (w_abort || (r_cnt == CNT_W'(1))) begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!drain_req)     w_state_next = ST_RUN;
        else if (&r_bubble) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!drain_req) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // State, bubble and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_bubble     <= '1;
      r_cnt        <= '0;
      r_hold_stage <= '0;
      r_busy       <= 1'b0;
      r_drained    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bubble     <= w_bubble_next;
      r_cnt        <= w_cnt_next;
      r_hold_stage <= w_hold_stage_next;
      r_busy       <= (w_state_next == ST_HOLD);
      r_drained    <= (w_state_next == ST_IDLE);
    end
  end

  assign valid   = ~r_bubble;
  assign busy    = r_busy;
  assign drained = r_drained;

`ifdef PIPE_CTRL_STATS_EN
  logic [STAT_W-1:0] r_stall_cycles;
  logic [STAT_W-1:0] r_flush_events;
  logic [STAT_W-1:0] r_bubble_retired;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles   <= '0;
      r_flush_events   <= '0;
      r_bubble_retired <= '0;
    end else begin
      if ((w_es != '0) && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + STAT_W'(1);
      if ((flush != '0) && (r_flush_events != '1))
        r_flush_events <= r_flush_events + STAT_W'(1);
      if (r_bubble[0] && !keep[0] && (r_bubble_retired != '1))
        r_bubble_retired <= r_bubble_retired + STAT_W'(1);
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign flush_events   = r_flush_events;
  assign bubble_retired = r_bubble_retired;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit (STAGES = 5); statistics checked when
// PIPE_CTRL_STATS_EN is defined.
module tb_pipe_ctrl_unit;

  logic       clk;
  logic       rst;
  logic [4:0] stall;
  logic [4:0] flush;
  logic       hold_req;
  logic [2:0] hold_stage;
  logic [3:0] hold_len;
  logic       drain_req;
  logic [4:0] keep;
  logic [4:0] dirty;
  logic [4:0] valid;
  logic       busy;
  logic       drained;
`ifdef PIPE_CTRL_STATS_EN
  logic [3:0] stall_cycles;
  logic [3:0] flush_events;
  logic [3:0] bubble_retired;
`endif

  int checks = 0;
  int errors = 0;

`ifdef PIPE_CTRL_STATS_EN
  pipe_ctrl_unit #(.STAGES(5), .CNT_W(4), .STAT_W(4)) dut (
`else
  pipe_ctrl_unit #(.STAGES(5), .CNT_W(4)) dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .hold_req   (hold_req),
    .hold_stage (hold_stage),
    .hold_len   (hold_len),
    .drain_req  (drain_req),
    .keep       (keep),
    .dirty      (dirty),
    .valid      (valid),
    .busy       (busy),
    .drained    (drained)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_cycles   (stall_cycles)
    , .flush_events   (flush_events)
    , .bubble_retired (bubble_retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    stall = '0; flush = '0; hold_req = 1'b0; drain_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [4:0] exp_v [6];
    exp_v = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
    rst = 1'b0; stall = '0; flush = '0; hold_req = 1'b0;
    hold_stage = '0; hold_len = '0; drain_req = 1'b0;
    #12;
    checks++;
    if (valid !== 5'b00000 || busy !== 1'b0 || drained !== 1'b0) begin
      errors++;
      $display("FAIL reset_state valid=%b busy=%b drained=%b req valid=00000 busy=0 drained=0", valid, busy, drained);
    end
    checks++;
    if (keep !== 5'b00000 || dirty !== 5'b11111) begin
      errors++;
      $display("FAIL reset_ctrl keep=%b dirty=%b req keep=00000 dirty=11111", keep, dirty);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      checks++;
      if (valid !== exp_v[k] || dirty !== ~exp_v[k]) begin
        errors++;
        $display("FAIL fill_step%0d valid=%b dirty=%b req valid=%b dirty=%b", k, valid, dirty, exp_v[k], ~exp_v[k]);
      end
    end
  endtask

  task automatic test_stall();
    stall = 5'b00100;
    #1;
    checks++;
    if (keep !== 5'b11100 || dirty !== 5'b11100) begin
      errors++;
      $display("FAIL stall_ctrl keep=%b dirty=%b req keep=11100 dirty=11100", keep, dirty);
    end
    tick();
    stall = '0;
    checks++;
    if (valid !== 5'b11011) begin
      errors++;
      $display("FAIL stall_valid got=%b req=11011", valid);
    end
    idle(5);
  endtask

  task automatic test_flush();
    flush = 5'b01000;
    #1;
    checks++;
    if (dirty !== 5'b11000 || keep !== 5'b00000) begin
      errors++;
      $display("FAIL flush_ctrl dirty=%b keep=%b req dirty=11000 keep=00000", dirty, keep);
    end
    tick();
    flush = '0;
    checks++;
    if (valid !== 5'b10011) begin
      errors++;
      $display("FAIL flush_valid got=%b req=10011", valid);
    end
    idle(5);
  endtask

  task automatic test_hold();
    hold_req = 1'b1; hold_stage = 3'd1; hold_len = 4'd3;
    #1;
    checks++;
    if (busy !== 1'b0 || keep !== 5'b00000) begin
      errors++;
      $display("FAIL hold_req_cycle busy=%b keep=%b req busy=0 keep=00000", busy, keep);
    end
    tick();
    hold_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || keep !== 5'b11110) begin
        errors++;
        $display("FAIL hold_cycle%0d busy=%b keep=%b req busy=1 keep=11110", k, busy, keep);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || keep !== 5'b00000) begin
      errors++;
      $display("FAIL hold_end busy=%b keep=%b req busy=0 keep=00000", busy, keep);
    end
    idle(5);
    // Abort the hold with an older-stage flush on the second hold cycle.
    hold_req = 1'b1; hold_stage = 3'd1; hold_len = 4'd3;
    tick();
    hold_req = 1'b0;
    tick();
    flush = 5'b00001;
    #1;
    checks++;
    if (keep !== 5'b11110 || dirty !== 5'b11111) begin
      errors++;
      $display("FAIL abort_ctrl keep=%b dirty=%b req keep=11110 dirty=11111", keep, dirty);
    end
    tick();
    flush = '0;
    checks++;
    if (busy !== 1'b0 || valid !== 5'b00000) begin
      errors++;
      $display("FAIL abort_state busy=%b valid=%b req busy=0 valid=00000", busy, valid);
    end
    tick();
    checks++;
    if (valid !== 5'b10000 || keep !== 5'b00000) begin
      errors++;
      $display("FAIL abort_refill valid=%b keep=%b req valid=10000 keep=00000", valid, keep);
    end
    idle(5);
  endtask

  task automatic test_hold_ignore();
    hold_req = 1'b1; hold_stage = 3'd2; hold_len = 4'd0;
    tick();
    hold_req = 1'b0;
    checks++;
    if (busy !== 1'b0 || keep !== 5'b00000 || valid !== 5'b11111) begin
      errors++;
      $display("FAIL hold_len0 busy=%b keep=%b valid=%b req busy=0 keep=00000 valid=11111", busy, keep, valid);
    end
  endtask

  task automatic test_drain();
    logic [4:0] seq [5];
    seq = '{5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
    drain_req = 1'b1;
    tick();
    checks++;
    if (valid !== 5'b11111 || keep !== 5'b10000) begin
      errors++;
      $display("FAIL drain_enter valid=%b keep=%b req valid=11111 keep=10000", valid, keep);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (valid !== seq[k] || keep[4] !== 1'b1 || drained !== 1'b0) begin
        errors++;
        $display("FAIL drain_step%0d valid=%b keep4=%b drained=%b req valid=%b keep4=1 drained=0", k, valid, keep[4], drained, seq[k]);
      end
    end
    tick();
    checks++;
    if (drained !== 1'b1 || valid !== 5'b00000) begin
      errors++;
      $display("FAIL drained_set drained=%b valid=%b req drained=1 valid=00000", drained, valid);
    end
    drain_req = 1'b0;
    tick();
    checks++;
    if (drained !== 1'b0) begin
      errors++;
      $display("FAIL drained_clear got=%b req=0", drained);
    end
    tick();
    checks++;
    if (valid !== 5'b10000) begin
      errors++;
      $display("FAIL drain_refill valid=%b req=10000", valid);
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    hold_req = 1'b1; hold_stage = 3'd0; hold_len = 4'd2; drain_req = 1'b1;
    tick();
    hold_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || keep !== 5'b11111) begin
      errors++;
      $display("FAIL hold_beats_drain busy=%b keep=%b req busy=1 keep=11111", busy, keep);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || keep !== 5'b00000) begin
      errors++;
      $display("FAIL hold_then_run busy=%b keep=%b req busy=0 keep=00000", busy, keep);
    end
    tick();
    checks++;
    if (keep !== 5'b10000) begin
      errors++;
      $display("FAIL deferred_drain keep=%b req=10000", keep);
    end
    drain_req = 1'b0;
    tick();
    checks++;
    if (keep !== 5'b00000 || drained !== 1'b0) begin
      errors++;
      $display("FAIL drain_abandon keep=%b drained=%b req keep=00000 drained=0", keep, drained);
    end
    idle(5);
  endtask

  task automatic test_async_reset();
    hold_req = 1'b1; hold_stage = 3'd2; hold_len = 4'd5;
    tick();
    hold_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_hold busy=%b req=1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 5'b00000 || drained !== 1'b0 || keep !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset busy=%b valid=%b drained=%b keep=%b req 0/00000/0/00000", busy, valid, drained, keep);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(6);
  endtask

`ifdef PIPE_CTRL_STATS_EN
  task automatic test_stats();
    rst = 1'b0;
    stall = 5'b00001;
    #3;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (stall_cycles !== 4'd15 || flush_events !== 4'd0 || bubble_retired !== 4'd0) begin
      errors++;
      $display("FAIL stats stall=%0d flush=%0d retired=%0d req 15/0/0", stall_cycles, flush_events, bubble_retired);
    end
    stall = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_hold();
    test_hold_ignore();
    test_drain();
    test_back_to_back();
    test_async_reset();
`ifdef PIPE_CTRL_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised pipeline control unit for an in-order pipeline of STAGES stages.
- Index 0 is the oldest stage (writeback side) and index STAGES-1 the youngest (fetch side).
- Tracks a bubble bit per stage and resolves per-stage stall and flush requests into keep/dirty controls.
- Adds two things the fixed 5-stage controller lacked: a multi-cycle hold request with an internal countdown, and a drain/quiesce handshake (for exceptions and debug halt).

Parameters:
- STAGES, 5, number of pipeline stages (>=2).
- CNT_W, 4, width of the hold length counter.
- STAT_W, 32, width of the statistics counters (only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  STAGES  per-stage stall request; the lowest set index wins
- flush  in  STAGES  per-stage flush request; the lowest set index wins
- hold_req  in  1  single-cycle pulse: stall stage hold_stage for hold_len cycles
- hold_stage  in  $clog2(STAGES)  stage index to hold
- hold_len  in  CNT_W  hold duration in cycles; 0 means ignore the request
- drain_req  in  1  level: quiesce the pipeline
- keep  out  STAGES  stage register must retain its value
- dirty  out  STAGES  stage contents are not to commit
- valid  out  STAGES  registered ~bubble
- busy  out  1  hold countdown active
- drained  out  1  pipeline empty and entry blocked

Behaviour:
- Reset: bubble = all ones (valid = 0), state RUN, hold counter 0, busy = 0, drained = 0.
- Effective stall vector: es = stall, OR a one-hot at hold_stage while in HOLD, OR bit STAGES-1 while in DRAIN or IDLE. Let s = lowest set index of es.
- Let f = lowest set index of flush.
- Next-bubble computation, applied in order:
  - Flush: nb = bubble with bits f..STAGES-1 forced to 1. If flush == 0, nb = bubble.
  - Stall present: bits above s are held, bit s = 1, bits below s take nb[i+1].
  - No stall: bubble' = {0, nb[STAGES-1:1]}.
- keep[i] = |es[i:0] (combinational).
- dirty[i] = bubble[i] | |flush[i:0] | |es[i:0].
- Hold counter:
  - A hold_req seen in RUN with hold_len != 0 loads the counter and moves to HOLD on the next edge.
  - es includes the hold for exactly hold_len cycles, starting the cycle after the request.
  - busy = (state == HOLD).
  - hold_req is ignored outside RUN or when hold_len == 0.
- Flush during HOLD:
  - A flush with f <= hold_stage aborts the hold: counter cleared, state returns to RUN on the next edge. The hold bit is still applied in the flush cycle.
  - A flush with f > hold_stage leaves the hold untouched.
- State machine (2-bit):
  - RUN -> HOLD on a valid hold_req.
  - RUN -> DRAIN when drain_req = 1 and no valid hold_req. If both arrive together, the hold wins and the drain is deferred.
  - HOLD -> RUN when the counter reaches 1 (the last hold cycle) or on an abort. A drain_req still high is then taken from RUN.
  - DRAIN -> IDLE on the first edge at which bubble is all ones.
  - IDLE -> RUN when drain_req = 0.
  - DRAIN or IDLE -> RUN immediately when drain_req drops.
- drained = (state == IDLE), registered.
- An asynchronous reset mid-operation returns everything to the reset values.

Optional Feature:
- Macro: PIPE_CTRL_STATS_EN.
- Defined:
  - Adds outputs stall_cycles [STAT_W], flush_events [STAT_W] and bubble_retired [STAT_W].
  - stall_cycles increments each cycle es != 0.
  - flush_events increments each cycle flush != 0.
  - bubble_retired increments each cycle bubble[0] = 1 while keep[0] = 0.
  - All three saturate at all ones and reset to 0.
- Not defined: these ports and their logic are absent.

Decomposition:
- Package pipe_pkg:
  - state typedef: RUN = 0, HOLD = 1, DRAIN = 2, IDLE = 3.
  - Function for the lowest-set index plus a found flag.
- One sub-module, pipe_prio_enc: parametrised lowest-set priority encoder, instantiated for es and for flush.

Test Plan:
All scenarios use STAGES = 5; vectors are written bit4..bit0.
1. Release reset with no stall or flush for 5 edges -> valid steps 00000, 10000, 11000, 11100, 11110, 11111; dirty = ~valid throughout.
2. With valid = 11111, stall = 00100 for one cycle -> keep = 11100 and dirty = 11100 that cycle; next valid = 11011.
3. With valid = 11111, flush = 01000 for one cycle -> dirty = 11000; next valid = 10011.
4. With valid = 11111, hold_req, hold_stage = 1, hold_len = 3 -> busy = 1 and keep = 11110 for 3 cycles, then busy = 0. Repeat with flush = 00001 on the 2nd hold cycle -> busy = 0 next cycle, valid = 10000.
5. With valid = 11111, drain_req = 1 -> valid goes 01111, 00111, 00011, 00001, 00000, with keep[4] = 1 throughout; drained = 1 at the next edge. drain_req = 0 -> drained = 0 next cycle and valid[4] refills.
6. With PIPE_CTRL_STATS_EN, STAT_W = 4, stall = 00001 held 20 cycles -> stall_cycles = 15 (saturated); flush_events = 0.
